// File: rtl/ctrl_seq.sv
// ctrl_seq: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driven by a 14-bit decoded control word.
// Ports: clk, rst (async active-high); sig (control word, sampled in DECODE), zero, bne, mem_ack;
//        ctl (latched control word), ir_we, pc_we, pc_sel, mem_req, mem_we, mem_byte, reg_we,
//        instr_done, state (3-bit encoding), stall_cnt.
// Optional: define CTRL_SEQ_STALL_CNT_EN to count cycles with mem_req=1 and mem_ack=0 (saturating).
module ctrl_seq #(
    parameter int CW     = 14,
    parameter int SCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     sig,
    input  logic              zero,
    input  logic              bne,
    input  logic              mem_ack,
    output logic [CW-1:0]     ctl,
    output logic              ir_we,
    output logic              pc_we,
    output logic              pc_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_byte,
    output logic              reg_we,
    output logic              instr_done,
    output logic [2:0]        state,
    output logic [SCNT_W-1:0] stall_cnt
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] ctl_q, ctl_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end
    // Outputs are also gated by rst so the memory request drops the moment reset asserts.
    always_comb begin
        state_d    = FETCH;
        ctl_d      = ctl_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_byte   = 1'b0;
        reg_we     = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ack;
                    pc_we   = mem_ack;
                    state_d = mem_ack ? DECODE : FETCH;
                end
                DECODE: begin
                    ctl_d   = sig;
                    state_d = EXEC;
                end
                EXEC: begin
                    pc_sel = 1'b1;
                    if (ctl_q[0]) begin
                        pc_we      = 1'b1;
                        reg_we     = ctl_q[5];
                        instr_done = 1'b1;
                    end else if (ctl_q[1]) begin
                        pc_we      = zero ^ bne;
                        instr_done = 1'b1;
                    end else if (ctl_q[4] || ctl_q[3]) begin
                        state_d = MEM;
                    end else if (ctl_q[5]) begin
                        state_d = WB;
                    end else begin
                        instr_done = 1'b1;
                    end
                end
                MEM: begin
                    mem_req    = 1'b1;
                    mem_we     = ctl_q[3];
                    mem_byte   = ctl_q[13];
                    instr_done = mem_ack && !ctl_q[4];
                    state_d    = !mem_ack ? MEM : ctl_q[4] ? WB : FETCH;
                end
                WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                end
                default: state_d = FETCH;
            endcase
        end
    end
    assign ctl   = ctl_q;
    assign state = state_q;
`ifdef CTRL_SEQ_STALL_CNT_EN
    logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
    always_comb stall_cnt_d = (mem_req && !mem_ack && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: randomized self-checking bench for ctrl_seq against a per-instruction behavioural model.
module tb_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] sig = '0;
    logic        zero = 1'b0, bne = 1'b0, mem_ack = 1'b0;
    logic [13:0] ctl;
    logic        ir_we, pc_we, pc_sel, mem_req, mem_we, mem_byte, reg_we, instr_done;
    logic [2:0]  state;
    logic [31:0] stall_cnt;
    int          errors = 0, checks = 0, stall_exp = 0;
    always #5 clk = ~clk;
    ctrl_seq dut (
        .clk(clk), .rst(rst), .sig(sig), .zero(zero), .bne(bne), .mem_ack(mem_ack),
        .ctl(ctl), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .mem_req(mem_req),
        .mem_we(mem_we), .mem_byte(mem_byte), .reg_we(reg_we), .instr_done(instr_done),
        .state(state), .stall_cnt(stall_cnt)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Runs one instruction starting mid-cycle in FETCH; fw/mw are the ack wait cycles in FETCH/MEM.
    task automatic run_instr(input logic [13:0] s, input logic z, input logic b, input int fw, input int mw);
        bit is_mem = !s[0] && !s[1] && (s[4] || s[3]);
        bit is_wb  = is_mem ? s[4] : (!s[0] && !s[1] && s[5]);
        bit link   = s[0] && s[5];
        int e_cyc  = fw + 3 + (is_mem ? mw + 1 : 0) + (is_wb ? 1 : 0);
        int e_pcw  = 1 + (s[0] ? 1 : s[1] ? int'(z ^ b) : 0);
        int e_req  = fw + 1 + (is_mem ? mw + 1 : 0);
        int e_wcyc = (is_mem && s[3]) ? mw + 1 : 0;
        int e_bcyc = (is_mem && s[13]) ? mw + 1 : 0;
        int e_reg  = (is_wb || link) ? 1 : 0;
        int st_e[$], st_o[$];
        int cyc = 0, run = 0, acks = 0, o_ir = 0, o_pcw = 0, o_tgt = 0, o_reg = 0, o_link = 0;
        int o_req = 0, o_wcyc = 0, o_bcyc = 0, o_bad = 0;
        bit done = 0;
        for (int i = 0; i <= fw; i++) st_e.push_back(0);
        st_e.push_back(1);
        st_e.push_back(2);
        if (is_mem) for (int i = 0; i <= mw; i++) st_e.push_back(3);
        if (is_wb) st_e.push_back(4);
        while (!done && cyc < 40) begin
            sig  = (cyc == fw + 1) ? s : 14'($urandom);
            zero = (cyc == fw + 2) ? z : 1'($urandom);
            bne  = (cyc == fw + 2) ? b : 1'($urandom);
            mem_ack = mem_req ? (run == (acks == 0 ? fw : mw)) : 1'($urandom);
            #1;
            st_o.push_back(int'(state));
            o_ir   += int'(ir_we);
            o_pcw  += int'(pc_we);
            o_tgt  += int'(pc_we && pc_sel);
            o_reg  += int'(reg_we);
            o_link += int'(pc_we && reg_we && pc_sel && instr_done);
            o_req  += int'(mem_req);
            o_wcyc += int'(mem_req && mem_we);
            o_bcyc += int'(mem_req && mem_byte);
            o_bad  += int'((!mem_req && (mem_we || mem_byte)) || (ir_we && pc_sel));
            if (mem_req && mem_ack) begin acks++; run = 0; end
            else if (mem_req) run++;
            done = instr_done;
            cyc++;
            @(posedge clk);
            #2;
        end
        stall_exp += fw + (is_mem ? mw : 0);
        chk("done", 32'(done), 32'd1);
        chk("cycles", 32'(cyc), 32'(e_cyc));
        chk("ir_we", 32'(o_ir), 32'd1);
        chk("pc_we", 32'(o_pcw), 32'(e_pcw));
        chk("pc_target", 32'(o_tgt), 32'(e_pcw - 1));
        chk("reg_we", 32'(o_reg), 32'(e_reg));
        chk("link", 32'(o_link), 32'(link ? 1 : 0));
        chk("mem_req", 32'(o_req), 32'(e_req));
        chk("mem_we", 32'(o_wcyc), 32'(e_wcyc));
        chk("mem_byte", 32'(o_bcyc), 32'(e_bcyc));
        chk("qualifiers", 32'(o_bad), 32'd0);
        chk("ctl", 32'(ctl), 32'(s));
        chk("end_state", 32'(state), 32'd0);
        for (int i = 0; i < st_e.size() && i < st_o.size(); i++) chk("state_trace", 32'(st_o[i]), 32'(st_e[i]));
`ifdef CTRL_SEQ_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'(stall_exp));
`else
        chk("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ctl", 32'(ctl), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_release_req", 32'(mem_req), 32'd1);
        #1;
        run_instr(14'h18A0, 1'b0, 1'b0, 0, 0);
        run_instr(14'h0C70, 1'b0, 1'b0, 0, 3);
        run_instr(14'h2C08, 1'b0, 1'b0, 0, 0);
        run_instr(14'h0602, 1'b1, 1'b0, 0, 0);
        run_instr(14'h0602, 1'b0, 1'b0, 0, 0);
        run_instr(14'h0602, 1'b0, 1'b1, 0, 0);
        run_instr(14'h0725, 1'b0, 1'b0, 0, 0);
        for (int n = 0; n < 40; n++)
            run_instr(14'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        // Park a load in MEM without ack, then reset asynchronously mid-cycle.
        for (int c = 0; c < 6; c++) begin
            sig = 14'h0C70;
            mem_ack = (state == 3'd0);
            @(posedge clk);
            #2;
        end
        mem_ack = 1'b0;
        #1;
        chk("mem_wait_req", 32'(mem_req), 32'd1);
        chk("mem_wait_state", 32'(state), 32'd3);
        rst = 1'b1;
        #1;
        chk("async_mem_req", 32'(mem_req), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_stall", stall_cnt, 32'd0);
        chk("async_ctl", 32'(ctl), 32'd0);
        mem_ack = 1'b1;
        #1;
        chk("ack_in_rst_ir", 32'(ir_we), 32'd0);
        chk("ack_in_rst_pc", 32'(pc_we), 32'd0);
        @(posedge clk);
        #2;
        chk("ack_in_rst_state", 32'(state), 32'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        stall_exp = 0;
        run_instr(14'h0C70, 1'b0, 1'b0, 1, 2);
        run_instr(14'h18A0, 1'b0, 1'b0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
